// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fpu_ctrl_pkg
// Brief    : Shared flag indices, rounding modes and operation type for the
//            single-precision add/sub issue control.
// Revision : 1.0
// ============================================================================
package fpu_ctrl_pkg;

  localparam int INVALID = 3;
  localparam int OVF     = 2;
  localparam int UNF     = 1;
  localparam int INEXACT = 0;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [1:0]  rm;
  } fpu_op_t;

endpackage
`default_nettype wire

// File: rtl/fpu_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_tag_pipe
// Brief    : DEPTH-deep {valid, id} shift register tracking in-flight ops.
// Revision : 1.0
// ============================================================================
module fpu_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_id,
  output logic o_valid,
  output logic o_id,
  output logic o_any
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_id[0]    <= i_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_id    = r_id[DEPTH-1];
  assign o_any   = |r_valid;

endmodule
`default_nettype wire

// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_arbiter
// Brief    : Round-robin issue of two requesters into one FP add datapath,
//            with in-order result routing and per-requester sticky flags.
// Revision : 1.0
// ============================================================================
module fpu_add_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic [1:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic [1:0]  req1_rm,
  input  logic        hold,
  output logic        dp_valid,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_sub,
  output logic [1:0]  dp_rm,
  input  logic [31:0] dp_res,
  input  logic [3:0]  dp_flags,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  sticky0,
  output logic [3:0]  sticky1,
  input  logic        clr0,
  input  logic        clr1,
  output logic        busy
);

  logic        r_prio;
  fpu_op_t     r_op;
  logic        r_dp_valid;
  logic        r_dp_id;
  logic        w_gnt0;
  logic        w_gnt1;
  fpu_op_t     w_op_sel;
  logic        w_tail_valid;
  logic        w_tail_id;
  logic        w_tag_any;
  logic        w_upd0;
  logic        w_upd1;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp_data;
  logic [3:0]  r_rsp_flags;
  logic [3:0]  r_sticky0;
  logic [3:0]  r_sticky1;

  // Readiness is gated by rst so nothing is accepted while the pipe is cleared.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = ~r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
    w_op_sel = w_gnt1 ? fpu_op_t'{a: req1_a, b: req1_b, sub: req1_sub, rm: req1_rm}
                      : fpu_op_t'{a: req0_a, b: req0_b, sub: req0_sub, rm: req0_rm};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_dp_valid <= 1'b0;
      r_dp_id    <= 1'b0;
      r_op       <= '0;
    end else begin
      r_dp_valid <= w_gnt0 | w_gnt1;
      if (w_gnt0 || w_gnt1) begin
        r_op    <= w_op_sel;
        r_dp_id <= w_gnt1;
        r_prio  <= w_gnt0;
      end
    end
  end

  fpu_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_dp_valid),
    .i_id    (r_dp_id),
    .o_valid (w_tail_valid),
    .o_id    (w_tail_id),
    .o_any   (w_tag_any)
  );

  assign w_upd0 = w_tail_valid & ~w_tail_id;
  assign w_upd1 = w_tail_valid &  w_tail_id;

  // A clear coinciding with a new result keeps only the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_flags  <= '0;
      r_sticky0    <= '0;
      r_sticky1    <= '0;
    end else begin
      r_rsp0_valid <= w_upd0;
      r_rsp1_valid <= w_upd1;
      if (w_tail_valid) begin
        r_rsp_data  <= dp_res;
        r_rsp_flags <= dp_flags;
      end
      if (clr0)        r_sticky0 <= w_upd0 ? dp_flags : 4'b0000;
      else if (w_upd0) r_sticky0 <= r_sticky0 | dp_flags;
      if (clr1)        r_sticky1 <= w_upd1 ? dp_flags : 4'b0000;
      else if (w_upd1) r_sticky1 <= r_sticky1 | dp_flags;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign dp_valid   = r_dp_valid;
  assign dp_a       = r_op.a;
  assign dp_b       = r_op.b;
  assign dp_sub     = r_op.sub;
  assign dp_rm      = r_op.rm;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_flags  = r_rsp_flags;
  assign sticky0    = r_sticky0;
  assign sticky1    = r_sticky1;
  assign busy       = r_dp_valid | w_tag_any | r_rsp0_valid | r_rsp1_valid;

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_add_arbiter
// Brief    : Directed bench; instance 0 has LATENCY=3, 1 has 1, 2 has 8.
// Revision : 1.0
// ============================================================================
module tb_fpu_add_arbiter;
  import fpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_sub, req1_sub, hold, clr0, clr1;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_rm, req1_rm;

  logic        rdy0 [3], rdy1 [3], dpv [3], dpsub [3], rsp0v [3], rsp1v [3], busy [3];
  logic [31:0] dpa [3], dpb [3], dpres [3], rspd [3];
  logic [1:0]  dprm [3];
  logic [3:0]  dpflags [3], rspf [3], st0 [3], st1 [3];
  logic [35:0] pipe [3][8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Datapath stand-in: {flags, result}; one fixed FP pair, integer add/sub otherwise.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !sub) return {4'h0, 32'h4040_0000};
    return {a[3:0] ^ b[3:0], sub ? a - b : a + b};
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 8);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 3 : ((k == 1) ? 1 : 8);
    assign {dpflags[k], dpres[k]} = pipe[k][L-1];
    fpu_add_arbiter #(.LATENCY(L)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(rdy0[k]), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sub(req0_sub), .req0_rm(req0_rm),
      .req1_valid(req1_valid), .req1_ready(rdy1[k]), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sub(req1_sub), .req1_rm(req1_rm),
      .hold(hold), .dp_valid(dpv[k]), .dp_a(dpa[k]), .dp_b(dpb[k]), .dp_sub(dpsub[k]),
      .dp_rm(dprm[k]), .dp_res(dpres[k]), .dp_flags(dpflags[k]),
      .rsp0_valid(rsp0v[k]), .rsp1_valid(rsp1v[k]), .rsp_data(rspd[k]), .rsp_flags(rspf[k]),
      .sticky0(st0[k]), .sticky1(st1[k]), .clr0(clr0), .clr1(clr1), .busy(busy[k])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pipe[k][0] <= model(dpa[k], dpb[k], dpsub[k]);
      for (int i = 1; i < 8; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; hold = 0; clr0 = 0; clr1 = 0;
    req0_a = '0; req0_b = '0; req0_sub = 0; req0_rm = RM_RNE;
    req1_a = '0; req1_b = '0; req1_sub = 0; req1_rm = RM_RNE;
  endtask

  task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [1:0] rm);
    if (!id) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; req0_rm = rm;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; req1_rm = rm;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  logic        id_q [20];
  logic [31:0] a_q [20], b_q [20];
  logic        sub_q [20];
  logic [31:0] ea;

  initial begin
    // Reset state, ready suppressed during reset
    idle();
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    step(); #1;
    chk("rst_rdy0", rdy0[0], 1'b0);
    chk("rst_rdy1", rdy1[0], 1'b0);
    step();
    rst = 0; idle(); #1;
    chk("rst_dpv", dpv[0], 1'b0);
    chk("rst_dp_ops", {dpa[0], dpb[0], dpsub[0], dprm[0]}, 64'd0);
    chk("rst_rsp", {rsp0v[0], rsp1v[0], rspd[0], rspf[0]}, 64'd0);
    chk("rst_sticky", {st0[0], st1[0]}, 8'd0);
    chk("rst_busy", busy[0], 1'b0);

    // Single issue
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 0, RM_RDN); #1;
    chk("single_rdy0", rdy0[0], 1'b1);
    chk("single_rdy1", rdy1[0], 1'b0);
    step(); req0_valid = 0; #1;
    chk("single_dpv", dpv[0], 1'b1);
    chk("single_dp_ops", {dpa[0], dpb[0], dpsub[0], dprm[0]},
        {32'h3F80_0000, 32'h4000_0000, 1'b0, RM_RDN});
    chk("single_busy", busy[0], 1'b1);
    step(); step(); step(); #1;
    chk("single_early", rsp0v[0], 1'b0);
    step(); #1;
    chk("single_rsp0v", rsp0v[0], 1'b1);
    chk("single_rsp1v", rsp1v[0], 1'b0);
    chk("single_data", rspd[0], 32'h4040_0000);
    chk("single_flags", rspf[0], 4'h0);
    chk("single_sticky0", st0[0], 4'h0);
    step(); #1;
    chk("single_rsp_done", rsp0v[0], 1'b0);
    chk("single_idle", busy[0], 1'b0);

    // Contention: both valid for 6 cycles
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        set_req(0, 32'h100 + 32'(c), 32'h10, 0, RM_RNE);
        set_req(1, 32'h200 + 32'(c), 32'h20, 0, RM_RNE);
      end else begin
        req0_valid = 0; req1_valid = 0;
      end
      #1;
      if (c < 6) begin
        chk($sformatf("cont_rdy0_c%0d", c), rdy0[0], (c % 2) == 0);
        chk($sformatf("cont_rdy1_c%0d", c), rdy1[0], (c % 2) == 1);
      end
      if (c >= 5 && c < 11) begin
        ea = ((c - 5) % 2 == 0) ? 32'h110 + 32'(c - 5) : 32'h220 + 32'(c - 5);
        chk($sformatf("cont_rsp0v_c%0d", c), rsp0v[0], ((c - 5) % 2) == 0);
        chk($sformatf("cont_rsp1v_c%0d", c), rsp1v[0], ((c - 5) % 2) == 1);
        chk($sformatf("cont_data_c%0d", c), rspd[0], ea);
      end
      step();
    end

    // Flags and clear-then-set
    do_reset();
    set_req(1, 32'h5, 32'h0, 0, RM_RTZ); #1;
    chk("flag_rdy1", rdy1[0], 1'b1);
    step();
    set_req(1, 32'h2, 32'h0, 0, RM_RTZ);
    step(); req1_valid = 0;
    step(); step(); #1;
    chk("flag_st1_pre", st1[0], 4'h0);
    step();
    clr1 = 1; #1;
    chk("flag_rsp1v_a", rsp1v[0], 1'b1);
    chk("flag_flags_a", rspf[0], 4'b0101);
    chk("flag_st1_a", st1[0], 4'b0101);
    chk("flag_st0_a", st0[0], 4'h0);
    step();
    clr1 = 0; #1;
    chk("flag_rsp1v_b", rsp1v[0], 1'b1);
    chk("flag_data_b", rspd[0], 32'h2);
    chk("flag_flags_b", rspf[0], 4'b0010);
    chk("flag_st1_b", st1[0], 4'b0010);
    chk("flag_st0_b", st0[0], 4'h0);
    step();
    clr1 = 1;
    step();
    clr1 = 0; #1;
    chk("flag_clr_only", st1[0], 4'h0);

    // Hold with two ops in flight
    do_reset();
    set_req(0, 32'h11, 32'h22, 0, RM_RNE);
    step();
    req0_valid = 0;
    set_req(1, 32'h50, 32'h10, 1, RM_RUP); #1;
    chk("hold_pre_rdy1", rdy1[0], 1'b1);
    step();
    hold = 1; req0_valid = 1;
    for (int c = 2; c < 8; c++) begin
      #1;
      chk($sformatf("hold_rdy_c%0d", c), {rdy0[0], rdy1[0]}, 2'b00);
      chk($sformatf("hold_rsp_c%0d", c), {rsp0v[0], rsp1v[0]}, {c == 5, c == 6});
      if (c == 5) chk("hold_data0", rspd[0], 32'h33);
      if (c == 6) chk("hold_data1", rspd[0], 32'h40);
      chk($sformatf("hold_busy_c%0d", c), busy[0], c < 7);
      step();
    end
    hold = 0; #1;
    chk("hold_release_rdy", {rdy0[0], rdy1[0]}, 2'b10);
    step();

    // Reset one cycle before the first result
    do_reset();
    set_req(0, 32'h1, 32'h1, 0, RM_RNE);
    step(); req0_valid = 0;
    set_req(1, 32'h2, 32'h2, 0, RM_RNE);
    step(); req1_valid = 0;
    set_req(0, 32'h3, 32'h3, 0, RM_RNE);
    step(); req0_valid = 0;
    rst = 1;
    step(); rst = 0; #1;
    chk("mrst_dp", {dpv[0], dpa[0], dpb[0]}, 65'd0);
    chk("mrst_rsp_regs", {rspd[0], rspf[0], st0[0], st1[0]}, 44'd0);
    for (int c = 4; c < 11; c++) begin
      #1;
      chk($sformatf("mrst_norsp_c%0d", c), {rsp0v[0], rsp1v[0], busy[0]}, 3'b000);
      step();
    end
    req0_valid = 1; req1_valid = 1; #1;
    chk("mrst_prio", {rdy0[0], rdy1[0]}, 2'b10);
    step();

    // Latency sweep over all three instances
    do_reset();
    for (int i = 0; i < 20; i++) begin
      id_q[i]  = 1'($urandom_range(0, 1));
      a_q[i]   = $urandom();
      b_q[i]   = $urandom();
      sub_q[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 32; c++) begin
      req0_valid = 0; req1_valid = 0;
      if (c < 20) set_req(id_q[c], a_q[c], b_q[c], sub_q[c], RM_RNE);
      #1;
      for (int k = 0; k < 3; k++) begin
        int  i;
        logic ev, e0, e1;
        if (c < 20)
          chk($sformatf("sweep_rdy_k%0d_c%0d", k, c), {rdy0[k], rdy1[k]},
              {~id_q[c], id_q[c]});
        i  = c - lat(k) - 2;
        ev = (i >= 0 && i < 20);
        e0 = 1'b0; e1 = 1'b0;
        if (ev) begin
          e0 = ~id_q[i];
          e1 = id_q[i];
        end
        chk($sformatf("sweep_rspv_k%0d_c%0d", k, c), {rsp0v[k], rsp1v[k]}, {e0, e1});
        if (ev)
          chk($sformatf("sweep_data_k%0d_c%0d", k, c), {rspf[k], rspd[k]},
              model(a_q[i], b_q[i], sub_q[i]));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
